// File: rtl/ssg_scan_scheduler.sv
// ssg_scan_scheduler: frame-boundary arbiter between two 16-bit requesters plus 4-digit scan, blanking and hex select.
// Optional leading-zero digit blanking is enabled by defining SSG_LEADING_ZERO_BLANK_EN.
module ssg_scan_scheduler #(
   parameter int TICK_DIV    = 50000,
   parameter int BLANK_CYC   = 500,
   parameter int HOLD_FRAMES = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_a,
   input  logic [15:0] data_a,
   input  logic        req_b,
   input  logic [15:0] data_b,
   input  logic [3:0]  digit_en,
   output logic        grant_a,
   output logic        grant_b,
   output logic [3:0]  anode,
   output logic [1:0]  seg_sel,
   output logic [3:0]  hex,
   output logic        frame_done
);
   localparam int PW = $clog2(TICK_DIV);
   localparam int HW = $clog2(HOLD_FRAMES + 1);
   typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;
   state_t        state;
   state_t        nxt;
   logic [PW-1:0] pcnt;
   logic [HW-1:0] hold_cnt;
   logic [15:0]   word;
   logic          last_a;
   logic          tick;
   logic          boundary;
   logic          hold_done;
   logic          suppress;
   logic          blank;
   assign tick      = pcnt == PW'(TICK_DIV - 1);
   assign boundary  = tick && seg_sel == 2'd3;
   assign hold_done = hold_cnt >= HW'(HOLD_FRAMES - 1);
   always_comb begin
      nxt = IDLE;
      case (state)
         IDLE:    nxt = (req_a && req_b) ? (last_a ? OWN_B : OWN_A) : req_a ? OWN_A : req_b ? OWN_B : IDLE;
         OWN_A:   nxt = !hold_done ? OWN_A : req_b ? OWN_B : !req_a ? IDLE : OWN_A;
         OWN_B:   nxt = !hold_done ? OWN_B : req_a ? OWN_A : !req_b ? IDLE : OWN_B;
         default: nxt = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         pcnt       <= '0;
         seg_sel    <= '0;
         state      <= IDLE;
         hold_cnt   <= '0;
         last_a     <= 1'b0;
         word       <= '0;
         grant_a    <= 1'b0;
         grant_b    <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         pcnt       <= tick ? '0 : pcnt + 1'b1;
         seg_sel    <= tick ? seg_sel + 1'b1 : seg_sel;
         frame_done <= boundary;
         // word is snapshotted once per frame so mid-frame data changes never tear the display
         if (boundary) begin
            state    <= nxt;
            grant_a  <= nxt == OWN_A;
            grant_b  <= nxt == OWN_B;
            word     <= nxt == OWN_A ? data_a : nxt == OWN_B ? data_b : '0;
            hold_cnt <= nxt != state ? '0 : (state == IDLE || hold_done) ? hold_cnt : hold_cnt + 1'b1;
            if (nxt != state && nxt != IDLE)
               last_a <= nxt == OWN_A;
         end
      end
   end
   assign hex = word[{seg_sel, 2'b00} +: 4];
`ifdef SSG_LEADING_ZERO_BLANK_EN
   assign suppress = seg_sel != 2'd0 && (word >> {seg_sel, 2'b00}) == 16'd0;
`else
   assign suppress = 1'b0;
`endif
   assign blank = state == IDLE || pcnt < PW'(BLANK_CYC) || !digit_en[seg_sel] || suppress;
   assign anode = blank ? 4'hF : ~(4'b0001 << seg_sel);
endmodule
